// File: rtl/systolic_result_drain.sv
// Result drain for the NxN systolic array: clears accumulators on start, waits out the
// array latency, snapshots/narrows the accumulators and holds them under valid/ready.
// Optional macro SYSTOLIC_DRAIN_SATURATE_EN: clamp instead of truncate, with per-element flags.
module systolic_result_drain #(
   parameter int N            = 4,
   parameter int ACC_W        = 16,
   parameter int OUT_W        = 8,
   parameter int DRAIN_CYCLES = 10
) (
   input  logic                              i_clk,
   input  logic                              i_arst_n,
   input  logic                              i_start,
   input  logic [N-1:0][N-1:0][ACC_W-1:0]    i_acc,
   input  logic                              i_resultReady,
   output logic                              o_clearAcc,
   output logic                              o_busy,
   output logic                              o_validResult,
   output logic [N-1:0][N-1:0][OUT_W-1:0]    o_c,
   output logic [N-1:0][N-1:0]               o_satFlags,
   output logic [1:0]                        o_dbg_state
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic                             capture;
   logic                             accept;
   logic                             valid_q;
   logic [N-1:0][N-1:0][OUT_W-1:0]   conv_c;
   logic [N-1:0][N-1:0][OUT_W-1:0]   c_q;

   // Handshake: a result transfers on any rising edge where o_validResult and
   // i_resultReady are both high; o_c/o_satFlags are stable while valid is high.
   assign accept = (state_q == S_HOLD) && i_resultReady;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      o_clearAcc = 1'b0;
      capture    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               o_clearAcc = 1'b1;
               cnt_d      = RELOAD;
               state_d    = S_COUNT;
            end
         end
         S_COUNT: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            // A start only counts when it coincides with acceptance of the held result.
            if (accept) begin
               if (i_start) begin
                  o_clearAcc = 1'b1;
                  cnt_d      = RELOAD;
                  state_d    = S_COUNT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         c_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         if (capture) begin
            c_q <= conv_c;
         end
         if (capture) begin
            valid_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef SYSTOLIC_DRAIN_SATURATE_EN
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

   logic [N-1:0][N-1:0] conv_sat;
   logic [N-1:0][N-1:0] sat_q;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign conv_sat[r][c] = i_acc[r][c] > SAT_MAX;
         assign conv_c[r][c]   = conv_sat[r][c] ? OUT_W'(SAT_MAX) : i_acc[r][c][OUT_W-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         sat_q <= '0;
      end else if (capture) begin
         sat_q <= conv_sat;
      end
   end

   assign o_satFlags = sat_q;
`else
   logic unused_acc_bits;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign conv_c[r][c] = i_acc[r][c][OUT_W-1:0];
      end
   end

   // Upper accumulator bits are intentionally dropped by truncation.
   assign unused_acc_bits = ^i_acc;
   assign o_satFlags      = '0;
`endif

   assign o_c           = c_q;
   assign o_validResult = valid_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: table vectors, randomized transactions against a
// behavioural narrowing/latency model, reset corner cases and a 2x2 instance.
module tb_systolic_result_drain;

   localparam int N     = 4;
   localparam int ACC_W = 16;
   localparam int OUT_W = 8;
   localparam int D     = 10;
   localparam int D2    = 4;
`ifdef SYSTOLIC_DRAIN_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef logic [N-1:0][N-1:0][ACC_W-1:0] acc_t;
   typedef logic [N-1:0][N-1:0][OUT_W-1:0] res_t;
   typedef logic [N-1:0][N-1:0]            flg_t;
   typedef logic [1:0][1:0][ACC_W-1:0]     acc2_t;
   typedef logic [1:0][1:0][OUT_W-1:0]     res2_t;
   typedef logic [1:0][1:0]                flg2_t;

   typedef struct {
      logic [15:0] v12;
      logic [15:0] vo;
      logic [7:0]  e12;
      logic [7:0]  eo;
      logic        f12;
      logic        fo;
      int          hold;
      bit          chain;
   } vec_t;

   logic  clk = 1'b0;
   logic  arst_n;
   logic  i_start, i_resultReady;
   acc_t  i_acc;
   logic  o_clearAcc, o_busy, o_validResult;
   res_t  o_c;
   flg_t  o_satFlags;
   logic [1:0] o_dbg_state;

   logic  s2_start, s2_ready;
   acc2_t s2_acc;
   logic  s2_clear, s2_busy, s2_valid;
   res2_t s2_c;
   flg2_t s2_sat;
   logic [1:0] s2_dbg;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   systolic_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .DRAIN_CYCLES(D)) dut (
      .i_clk(clk), .i_arst_n(arst_n), .i_start(i_start), .i_acc(i_acc),
      .i_resultReady(i_resultReady), .o_clearAcc(o_clearAcc), .o_busy(o_busy),
      .o_validResult(o_validResult), .o_c(o_c), .o_satFlags(o_satFlags),
      .o_dbg_state(o_dbg_state)
   );

   systolic_result_drain #(.N(2), .ACC_W(ACC_W), .OUT_W(OUT_W), .DRAIN_CYCLES(D2)) dut2 (
      .i_clk(clk), .i_arst_n(arst_n), .i_start(s2_start), .i_acc(s2_acc),
      .i_resultReady(s2_ready), .o_clearAcc(s2_clear), .o_busy(s2_busy),
      .o_validResult(s2_valid), .o_c(s2_c), .o_satFlags(s2_sat),
      .o_dbg_state(s2_dbg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference narrowing: value modulo 2^OUT_W, or clamped to the max when saturating.
   function automatic logic [7:0] narrow(input logic [15:0] a);
      if (SAT && a > 16'd255) return 8'd255;
      return 8'(a % 16'd256);
   endfunction

   function automatic logic clamp_flag(input logic [15:0] a);
      return SAT && (a > 16'd255);
   endfunction

   function automatic res_t model_c(input acc_t a);
      res_t r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            r[i][j] = narrow(a[i][j]);
      return r;
   endfunction

   function automatic flg_t model_f(input acc_t a);
      flg_t f;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            f[i][j] = clamp_flag(a[i][j]);
      return f;
   endfunction

   task automatic do_start();
      i_start = 1'b1;
      #1;
      chk("clear_on_start", o_clearAcc, 1'b1);
      tick();
      i_start = 1'b0;
   endtask

   // Entered in the cycle after the start edge; runs COUNT, HOLD with backpressure, accept.
   task automatic run_txn(input acc_t a, input acc_t hold_a, input int hold_cycles,
                          input bit chain, input res_t ec, input flg_t ef);
      int n;
      i_acc = a;
      n = 0;
      chk("busy_in_count", o_busy, 1'b1);
      while (!o_validResult && n < D + 20) begin
         if (n == 1) begin
            i_start       = 1'b1;
            i_resultReady = 1'b1;
            #1;
            chk("stray_start_no_clear", o_clearAcc, 1'b0);
         end
         tick();
         i_start       = 1'b0;
         i_resultReady = 1'b0;
         n++;
      end
      chk("latency", n, D);
      chk("result", o_c, ec);
      chk("sat_flags", o_satFlags, ef);
      i_acc = hold_a;
      for (int i = 0; i < hold_cycles; i++) begin
         i_start = 1'($urandom_range(0, 1));
         #1;
         chk("hold_no_clear", o_clearAcc, 1'b0);
         tick();
         i_start = 1'b0;
         chk("hold_valid", o_validResult, 1'b1);
         chk("hold_result", o_c, ec);
         chk("hold_flags", o_satFlags, ef);
      end
      i_resultReady = 1'b1;
      i_start       = chain;
      #1;
      chk("accept_clear", o_clearAcc, chain);
      tick();
      i_resultReady = 1'b0;
      i_start       = 1'b0;
      chk("valid_drop", o_validResult, 1'b0);
      chk("result_kept", o_c, ec);
      chk("busy_after_accept", o_busy, chain);
   endtask

   initial begin
      vec_t  vt[6];
      acc_t  a, hold_a;
      res_t  ec;
      flg_t  ef;
      acc2_t p2;
      res2_t ec2;
      flg2_t ef2;
      logic [7:0] ma[2][2];
      logic [7:0] mb[2][2];
      bit    prev_chain;
      bit    ch;
      int    n;

      vt[0] = '{16'h0023, 16'h0023, 8'h23, 8'h23, 1'b0, 1'b0, 7, 1'b0};
      vt[1] = '{16'h01FF, 16'h0042, 8'hFF, 8'h42, SAT, 1'b0, 2, 1'b1};
      vt[2] = '{16'h0305, 16'h0042, SAT ? 8'hFF : 8'h05, 8'h42, SAT, 1'b0, 0, 1'b1};
      vt[3] = '{16'h00FF, 16'h0100, 8'hFF, SAT ? 8'hFF : 8'h00, 1'b0, SAT, 1, 1'b0};
      vt[4] = '{16'h0000, 16'hFFFF, 8'h00, 8'hFF, 1'b0, SAT, 3, 1'b1};
      vt[5] = '{16'h0100, 16'h00AB, SAT ? 8'hFF : 8'h00, 8'hAB, SAT, 1'b0, 0, 1'b0};

      arst_n = 1'b0;
      i_start = 1'b0; i_resultReady = 1'b0; i_acc = '0;
      s2_start = 1'b0; s2_ready = 1'b0; s2_acc = '0;
      tick(); tick();
      chk("rst_valid", o_validResult, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_clear", o_clearAcc, 1'b0);
      chk("rst_c", o_c, '0);
      chk("rst_flags", o_satFlags, '0);
      arst_n = 1'b1;
      tick(); tick();

      // Table vectors: latency, backpressure, back-to-back, narrowing boundaries.
      prev_chain = 1'b0;
      for (int v = 0; v < 6; v++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               a[r][c]  = (r == 1 && c == 2) ? vt[v].v12 : vt[v].vo;
               ec[r][c] = (r == 1 && c == 2) ? vt[v].e12 : vt[v].eo;
               ef[r][c] = (r == 1 && c == 2) ? vt[v].f12 : vt[v].fo;
               hold_a[r][c] = 16'h0011;
            end
         if (!prev_chain) do_start();
         run_txn(a, hold_a, vt[v].hold, vt[v].chain, ec, ef);
         prev_chain = vt[v].chain;
         if (!prev_chain) tick();
      end

      // Randomized transactions against the model.
      prev_chain = 1'b0;
      for (int t = 0; t < 25; t++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               a[r][c] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255))
                                                     : 16'($urandom_range(0, 65535));
               hold_a[r][c] = 16'($urandom_range(0, 65535));
            end
         ch = (t == 24) ? 1'b0 : 1'($urandom_range(0, 1));
         if (!prev_chain) do_start();
         run_txn(a, hold_a, int'($urandom_range(0, 4)), ch, model_c(a), model_f(a));
         prev_chain = ch;
         if (!prev_chain && $urandom_range(0, 1) == 1) tick();
      end

      // Reset in HOLD drops the held result.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            i_acc[r][c] = 16'h0155;
      do_start();
      n = 0;
      while (!o_validResult && n < D + 20) begin
         tick();
         n++;
      end
      chk("hold_rst_pre_valid", o_validResult, 1'b1);
      arst_n = 1'b0;
      #1;
      chk("hold_rst_valid", o_validResult, 1'b0);
      chk("hold_rst_c", o_c, '0);
      chk("hold_rst_flags", o_satFlags, '0);
      tick();
      arst_n = 1'b1;
      tick();

      // Reset mid-COUNT, then quiet for 20 cycles.
      do_start();
      tick(); tick(); tick();
      arst_n = 1'b0;
      #1;
      chk("cnt_rst_busy", o_busy, 1'b0);
      tick();
      arst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post_rst_valid", o_validResult, 1'b0);
         chk("post_rst_busy", o_busy, 1'b0);
         chk("post_rst_c", o_c, '0);
      end

      // 2x2 instance with a short drain, driven with real matrix products.
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
               ma[r][c] = 8'($urandom_range(0, 25));
               mb[r][c] = 8'($urandom_range(0, 25));
            end
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
               p2[r][c]  = 16'(ma[r][0] * mb[0][c] + ma[r][1] * mb[1][c]);
               ec2[r][c] = narrow(p2[r][c]);
               ef2[r][c] = clamp_flag(p2[r][c]);
            end
         s2_acc   = p2;
         s2_start = 1'b1;
         #1;
         chk("n2_clear", s2_clear, 1'b1);
         tick();
         s2_start = 1'b0;
         n = 0;
         while (!s2_valid && n < D2 + 20) begin
            tick();
            n++;
         end
         chk("n2_latency", n, D2);
         chk("n2_result", s2_c, ec2);
         chk("n2_flags", s2_sat, ef2);
         s2_ready = 1'b1;
         tick();
         s2_ready = 1'b0;
         chk("n2_valid_drop", s2_valid, 1'b0);
         chk("n2_idle", s2_busy, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
